// File: rtl/hazard_unit.sv
// Decode-stage hazard controller: load-use bubbles, branch/jump squashes and
// data-memory wait freezes, with a saturating bubble counter and timeout flag.
module hazard_unit #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             Stall,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             IDEXWrite,
  output logic             EXMEMWrite,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic {RUN, MEMWAIT} state_t;

  state_t            state_q, state_d;
  logic              pend_q, pend_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_q, tmo_d;

  logic load_use;
  logic branch_eff;

  assign load_use = ex_MemRead && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // A branch captured while frozen is replayed on the first unfrozen cycle.
  assign branch_eff = ex_branch_taken || ((state_q == MEMWAIT) && pend_q);

  always_comb begin
    Stall      = 1'b0;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    IDEXWrite  = 1'b1;
    EXMEMWrite = 1'b1;
    if (rst) begin
      Stall     = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (mem_busy) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEMWrite = 1'b0;
    end else if (branch_eff) begin
      Stall     = 1'b1;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (load_use) begin
      Stall     = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end else if (id_jump) begin
      IFIDFlush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    wait_d  = wait_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    if (mem_busy) begin
      // The entry cycle counts as the first busy cycle of the wait.
      state_d = MEMWAIT;
      if (ex_branch_taken) pend_d = 1'b1;
      if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
      if (wait_d == WAIT_MAX) tmo_d = 1'b1;
    end else begin
      state_d = RUN;
      pend_d  = 1'b0;
      wait_d  = '0;
    end
    if (Stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      wait_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign stall_count = cnt_q;
  assign mem_timeout = tmo_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: scoreboarded control-vector checks on a
// default instance and a narrow-counter instance sharing the same stimulus.
module tb_hazard_unit;

  logic clk, rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, id_jump, ex_MemRead, ex_branch_taken, mem_busy;

  logic a_stall, a_pcw, a_ifw, a_iff, a_idf, a_idw, a_exw, a_tmo;
  logic [15:0] a_cnt;
  logic b_stall, b_pcw, b_ifw, b_iff, b_idf, b_idw, b_exw, b_tmo;
  logic [3:0] b_cnt;

  hazard_unit #(.MEM_TIMEOUT(64), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .Stall(a_stall), .PCWrite(a_pcw), .IFIDWrite(a_ifw), .IFIDFlush(a_iff),
    .IDEXFlush(a_idf), .IDEXWrite(a_idw), .EXMEMWrite(a_exw),
    .stall_count(a_cnt), .mem_timeout(a_tmo)
  );

  hazard_unit #(.MEM_TIMEOUT(64), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .Stall(b_stall), .PCWrite(b_pcw), .IFIDWrite(b_ifw), .IFIDFlush(b_iff),
    .IDEXFlush(b_idf), .IDEXWrite(b_idw), .EXMEMWrite(b_exw),
    .stall_count(b_cnt), .mem_timeout(b_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {Stall, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, IDEXWrite, EXMEMWrite}
  localparam logic [6:0] V_NORM = 7'b0110011;
  localparam logic [6:0] V_FRZ  = 7'b0000000;
  localparam logic [6:0] V_BR   = 7'b1111111;
  localparam logic [6:0] V_LU   = 7'b1000011;
  localparam logic [6:0] V_JMP  = 7'b0111011;
  localparam logic [6:0] V_RST  = 7'b1001111;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int m_cnt    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                        input logic jmp, input logic mr, input logic [4:0] ert,
                        input logic br, input logic busy);
    id_rs = rs; id_rt = rt; id_uses_rt = uses; id_jump = jmp;
    ex_MemRead = mr; ex_rt = ert; ex_branch_taken = br; mem_busy = busy;
  endtask

  // Drive happens at a negedge; outputs are compared 2ns later, before the posedge.
  task automatic cyc(input string tag, input logic [6:0] exp);
    sb_item_t it;
    sb.push_back('{tag, exp});
    #2;
    it = sb.pop_front();
    check({it.tag, "_a"}, 32'({a_stall, a_pcw, a_ifw, a_iff, a_idf, a_idw, a_exw}), 32'(it.exp));
    check({it.tag, "_b"}, 32'({b_stall, b_pcw, b_ifw, b_iff, b_idf, b_idw, b_exw}), 32'(it.exp));
    if (exp[6] && !rst) m_cnt++;
    @(negedge clk);
  endtask

  task automatic chk_cnt(input string tag);
    check({tag, "_cnt16"}, 32'(a_cnt), 32'((m_cnt > 65535) ? 65535 : m_cnt));
    check({tag, "_cnt4"},  32'(b_cnt), 32'((m_cnt > 15) ? 15 : m_cnt));
  endtask

  task automatic chk_tmo(input string tag, input logic exp);
    check({tag, "_tmo_a"}, 32'(a_tmo), 32'(exp));
    check({tag, "_tmo_b"}, 32'(b_tmo), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cyc("reset", V_RST);
    chk_cnt("reset");
    chk_tmo("reset", 1'b0);

    rst = 1'b0;
    cyc("release", V_NORM);
    chk_cnt("release");
    chk_tmo("release", 1'b0);

    set_in(5, 0, 0, 0, 1, 5, 0, 0); cyc("lu_rs", V_LU);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc("lu_after", V_NORM);
    chk_cnt("lu");
    set_in(0, 0, 0, 0, 1, 0, 0, 0); cyc("lu_r0", V_NORM);
    set_in(0, 7, 0, 0, 1, 7, 0, 0); cyc("rt_unused", V_NORM);
    set_in(0, 7, 1, 0, 1, 7, 0, 0); cyc("rt_used", V_LU);
    set_in(0, 0, 0, 1, 0, 0, 0, 0); cyc("jump", V_JMP);
    set_in(5, 0, 0, 1, 1, 5, 0, 0); cyc("lu_jump", V_LU);
    set_in(5, 0, 0, 1, 0, 0, 0, 0); cyc("jump_retry", V_JMP);
    set_in(5, 0, 0, 0, 1, 5, 1, 0); cyc("br_lu", V_BR);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc("br_after", V_NORM);
    chk_cnt("br");

    set_in(0, 0, 0, 0, 0, 0, 0, 1); cyc("mw1", V_FRZ);
    set_in(0, 0, 0, 0, 0, 0, 1, 1); cyc("mw2_br", V_FRZ);
    set_in(0, 0, 0, 0, 0, 0, 0, 1); cyc("mw3", V_FRZ);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc("mw_release", V_BR);
    cyc("mw_after", V_NORM);
    chk_cnt("mw");

    set_in(0, 0, 0, 0, 0, 0, 1, 1); cyc("entry_br", V_FRZ);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc("entry_release", V_BR);
    cyc("entry_after", V_NORM);

    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 64; i++) begin
      cyc("tmo_frz", V_FRZ);
      if (i == 9) chk_tmo("tmo_early", 1'b0);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc("tmo_release", V_NORM);
    chk_tmo("tmo_set", 1'b1);
    cyc("tmo_idle", V_NORM);
    chk_tmo("tmo_sticky", 1'b1);
    chk_cnt("tmo");

    set_in(0, 0, 0, 0, 0, 0, 1, 1); cyc("rstmw_frz", V_FRZ);
    rst = 1'b1;
    m_cnt = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc("rstmw_rst", V_RST);
    chk_tmo("rstmw", 1'b0);
    rst = 1'b0;
    cyc("rstmw_noflush", V_NORM);
    chk_cnt("rstmw");

    set_in(9, 0, 0, 0, 1, 9, 0, 0);
    for (int i = 0; i < 20; i++) cyc("sat_lu", V_LU);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc("sat_after", V_NORM);
    chk_cnt("sat");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller in the decode stage.
- Generates the Stall input consumed by ControlUnit, plus PC/IF-ID write enables, pipeline flushes, and freeze enables for the ID/EX and EX/MEM registers.
- Handles load-use bubbles, taken-branch/jump squashes and multi-cycle data-memory waits, including a branch that resolves while memory is busy.
- Keeps a saturating bubble-cycle counter and a sticky memory-timeout flag.

Parameters:
- MEM_TIMEOUT, 64, consecutive mem_busy cycles after which mem_timeout sets.
- CNT_W, 16, width of stall_count.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, store, branches).
- id_jump  in  1  Jump or JmpandLink from ControlUnit for the ID instruction.
- ex_MemRead  in  1  MemRead of instruction in EX.
- ex_rt  in  5  destination rt of the load in EX.
- ex_branch_taken  in  1  branch in EX resolved taken (BranchEqual/BranchnotEqual qualified with ALU zero).
- mem_busy  in  1  data memory not ready this cycle.
- Stall  out  1  to ControlUnit; 1 zeroes all control signals (bubble).
- PCWrite  out  1  PC register enable.
- IFIDWrite  out  1  IF/ID register enable.
- IFIDFlush  out  1  IF/ID loads a NOP (opcode 0).
- IDEXFlush  out  1  ID/EX loads a NOP.
- IDEXWrite  out  1  ID/EX register enable.
- EXMEMWrite  out  1  EX/MEM register enable.
- stall_count  out  CNT_W  saturating count of cycles with Stall=1, excluding reset.
- mem_timeout  out  1  sticky; set when the MEM_TIMEOUT limit is reached.

Behaviour:
- State register: RUN, MEMWAIT. Also registered: pending_flush (1b), wait_cnt (ceil(log2(MEM_TIMEOUT+1)) bits), stall_count, mem_timeout.
- Reset (asynchronous):
  - State RUN; pending_flush=0; wait_cnt=0; stall_count=0; mem_timeout=0.
  - While rst=1, outputs are forced: Stall=1, PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1, IDEXWrite=1, EXMEMWrite=1.
  - Reset mid-MEMWAIT discards any pending flush.
- Outputs are combinational from state and inputs (same-cycle, zero latency). All state updates happen on the clock edge.
- load_use = ex_MemRead & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Priority in RUN (highest first):
  1. mem_busy=1: freeze. PCWrite=IFIDWrite=IDEXWrite=EXMEMWrite=0, Stall=0, no flushes. Next state MEMWAIT. If ex_branch_taken=1 this cycle, pending_flush<=1.
  2. ex_branch_taken=1: IFIDFlush=1, IDEXFlush=1, Stall=1, PCWrite=1 (branch target loads), IFIDWrite=1. Load_use and jump are ignored because the ID instruction is squashed.
  3. load_use=1: Stall=1, PCWrite=0, IFIDWrite=0, IDEXFlush=0 (bubble comes through Stall). Exactly one bubble per hazard; the condition clears naturally when the load advances.
  4. id_jump=1: IFIDFlush=1, PCWrite=1, Stall=0.
  5. Otherwise: all enables 1, Stall=0, flushes 0.
- MEMWAIT:
  - While mem_busy=1: same freeze outputs as above; wait_cnt increments, saturating at MEM_TIMEOUT. Reaching MEM_TIMEOUT sets mem_timeout (sticky until rst).
  - On the first cycle with mem_busy=0: wait_cnt<=0, state<=RUN, and outputs follow the RUN priority, except that if pending_flush=1 the cycle behaves as ex_branch_taken=1. pending_flush then clears.
- ex_branch_taken asserted during MEMWAIT while frozen is also captured into pending_flush.
- stall_count increments on each clock edge where Stall=1 and rst=0, saturating at all-ones with no wrap.
- A simultaneous load_use and id_jump produces the load-use stall only; the jump is re-evaluated next cycle.

Test Plan:
- Reset release: rst 1->0 with all inputs 0 -> Stall=0, PCWrite=IFIDWrite=IDEXWrite=EXMEMWrite=1, stall_count=0, mem_timeout=0.
- Load-use: ex_MemRead=1, ex_rt=5, id_rs=5 for one cycle -> Stall=1, PCWrite=0, IFIDWrite=0 for 1 cycle; stall_count=1. Same stimulus with ex_rt=0 -> no stall.
- rt-only hazard: ex_rt=7, id_rt=7, id_uses_rt=0 -> no stall; id_uses_rt=1 -> stall.
- Branch taken together with load_use: IFIDFlush=IDEXFlush=1, PCWrite=1, Stall=1; next cycle normal.
- Branch during memory wait: mem_busy=1 for 3 cycles with ex_branch_taken pulsed in cycle 2 -> all enables 0 for 3 cycles; the cycle mem_busy falls gives IFIDFlush=IDEXFlush=1; the following cycle has no flush.
- Timeout and saturation: mem_busy held 64 cycles -> mem_timeout=1 and stays 1 after mem_busy drops. With CNT_W=4 and 20 stall cycles -> stall_count=15.
